// File: rtl/fpu_pkg.sv
// Shared FPU constants and the unpacked binary32 view used by the squaring datapath.
package fpu_pkg;

  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float_t;

  function automatic logic [23:0] mant_of(input float_t f);
    return {1'b1, f.frac};
  endfunction

endpackage

// File: rtl/fsquare_round.sv
// Combinational output stage of fsquare: normalise the 48-bit square, round half-up,
// form the biased exponent and select zero / +inf / NaN / finite result.
module fsquare_round
  import fpu_pkg::*;
(
  input  logic [47:0] p_i,
  input  logic [7:0]  e_i,
  input  logic        is_inf_i,
  input  logic        is_nan_i,
  output logic [31:0] y_o
);

  localparam logic signed [9:0] EXP_OVF = 10'(EXP_MAX);

  logic              norm_n;
  logic [22:0]       mant;
  logic              rnd;
  logic [23:0]       mant_sum;
  logic              carry;
  logic [9:0]        exp_w;
  logic signed [9:0] exp_s;
  logic              unused_low;

  // Half-up rounding looks only at the first dropped bit, so the low product bits are dead.
  assign unused_low = ^p_i[21:0];

  always_comb begin
    norm_n   = p_i[47];
    mant     = norm_n ? p_i[46:24] : p_i[45:23];
    rnd      = norm_n ? p_i[23]    : p_i[22];
    mant_sum = {1'b0, mant} + {23'd0, rnd};
    carry    = mant_sum[23];
    exp_w    = {1'b0, e_i, 1'b0} + {9'd0, norm_n} + {9'd0, carry} - 10'(BIAS);
    exp_s    = $signed(exp_w);

    y_o = 32'h0000_0000;
    if (is_nan_i) begin
      y_o = QNAN;
    end else if (is_inf_i) begin
      y_o = POS_INF;
    end else if (e_i == 8'd0) begin
      y_o = 32'h0000_0000;
    end else if (exp_s >= EXP_OVF) begin
      y_o = POS_INF;
    end else if (exp_s <= 10'sd0) begin
      y_o = 32'h0000_0000;
    end else begin
      y_o = {1'b0, exp_w[7:0], mant_sum[22:0]};
    end
  end

endmodule

// File: rtl/fsquare.sv
// Pipelined binary32 squarer y = x*x: 3-stage, result 3 edges after acceptance, one op/cycle;
// whole pipe stalls while out_valid && !out_ready. FSQUARE_SPECIAL_EN enables inf/NaN decode of e=255.
module fsquare
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  logic        adv;

  logic        s1_vld_q;
  float_t      x1_q;

  logic        s2_vld_q;
  logic [47:0] p2_q;
  logic [7:0]  e2_q;
  logic        inf2_q;
  logic        nan2_q;

  logic        out_vld_q;
  logic [31:0] y_q;

  logic [23:0] m1;
  logic [47:0] p_d;
  logic        inf_d;
  logic        nan_d;
  logic [31:0] y_d;
  logic        unused_sign;

  assign adv      = !out_vld_q || out_ready;
  assign in_ready = adv;

  assign m1          = mant_of(x1_q);
  assign p_d         = {24'd0, m1} * {24'd0, m1};
  assign unused_sign = x1_q.sign;

`ifdef FSQUARE_SPECIAL_EN
  assign inf_d = (x1_q.exp == 8'hFF) && (x1_q.frac == 23'd0);
  assign nan_d = (x1_q.exp == 8'hFF) && (x1_q.frac != 23'd0);
`else
  assign inf_d = 1'b0;
  assign nan_d = 1'b0;
`endif

  fsquare_round u_round (
    .p_i      (p2_q),
    .e_i      (e2_q),
    .is_inf_i (inf2_q),
    .is_nan_i (nan2_q),
    .y_o      (y_d)
  );

  // Valid bits and the output register are the only reset state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      y_q       <= 32'h0000_0000;
    end else if (adv) begin
      s1_vld_q  <= in_valid;
      s2_vld_q  <= s1_vld_q;
      out_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        y_q <= y_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      x1_q <= x;
    end
    if (adv) begin
      p2_q   <= p_d;
      e2_q   <= x1_q.exp;
      inf2_q <= inf_d;
      nan2_q <= nan_d;
    end
  end

  assign out_valid = out_vld_q;
  assign y         = y_q;

endmodule

// File: tb/tb_fsquare.sv
// Scoreboard bench for fsquare: driver queues hand-computed squares, monitor pops on each output.
module tb_fsquare;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  fsquare dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit timed_mode;

  logic [31:0] exp_q[$];
  int          cyc_q[$];
  bit          tim_q[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h, expected no output", y);
      end else begin
        logic [31:0] e;
        int          c;
        bit          t;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        t = tim_q.pop_front();
        check("result", y, e);
        if (t) check("latency", 32'(cyc - c), 32'd3);
      end
    end
  end

  task automatic send(input logic [31:0] v, input logic [31:0] e);
    bit done;
    done = 1'b0;
    @(negedge clk);
    x        = v;
    in_valid = 1'b1;
    #1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (in_ready) begin
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        tim_q.push_back(timed_mode);
        done = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
        #1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: x=%h in_ready=%b, expected 1", v, in_ready);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    x        = 32'hDEAD_BEEF;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [31:0] vin [12];
  logic [31:0] vexp[12];
  logic [31:0] sin [6];
  logic [31:0] sexp[6];

  initial begin
    vin[0]  = 32'h4040_0000; vexp[0]  = 32'h4110_0000; // 3.0 -> 9.0
    vin[1]  = 32'hBFC0_0000; vexp[1]  = 32'h4010_0000; // -1.5 -> 2.25
    vin[2]  = 32'h3FFF_FFFF; vexp[2]  = 32'h407F_FFFE;
    vin[3]  = 32'h7F00_0000; vexp[3]  = 32'h7F80_0000;
    vin[4]  = 32'h1F80_0000; vexp[4]  = 32'h0000_0000;
    vin[5]  = 32'h0000_0001; vexp[5]  = 32'h0000_0000;
    vin[6]  = 32'h3F80_0800; vexp[6]  = 32'h3F80_1001; // rnd = 1
    vin[7]  = 32'h2000_0000; vexp[7]  = 32'h0080_0000; // smallest normal result
    vin[8]  = 32'h5F80_0000; vexp[8]  = 32'h7F80_0000; // E = 255
    vin[9]  = 32'h5F7F_FFFF; vexp[9]  = 32'h7F7F_FFFE; // E = 254
    vin[10] = 32'h7F80_0000; vexp[10] = 32'h7F80_0000;
`ifdef FSQUARE_SPECIAL_EN
    vin[11] = 32'h7F80_0001; vexp[11] = 32'h7FC0_0000;
`else
    vin[11] = 32'h7F80_0001; vexp[11] = 32'h7F80_0000;
`endif
    sin[0] = 32'h3F80_0000; sexp[0] = 32'h3F80_0000;
    sin[1] = 32'h4000_0000; sexp[1] = 32'h4080_0000;
    sin[2] = 32'h4040_0000; sexp[2] = 32'h4110_0000;
    sin[3] = 32'h3FC0_0000; sexp[3] = 32'h4010_0000;
    sin[4] = 32'h4080_0000; sexp[4] = 32'h4180_0000;
    sin[5] = 32'h40A0_0000; sexp[5] = 32'h41C8_0000;

    rstn       = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    x          = 32'h0;
    timed_mode = 1'b1;
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_y", y, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Free-flowing directed vectors, back-to-back.
    for (int i = 0; i < 12; i++) send(vin[i], vexp[i]);
    idle();
    drain();

    // Back-pressure: three acceptances fill the pipe, then in_ready must drop.
    timed_mode = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(sin[i], sexp[i]);
    @(negedge clk);
    x        = sin[3];
    in_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_y_stable", y, sexp[0]);
      @(negedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 3; i < 6; i++) send(sin[i], sexp[i]);
    idle();
    drain();

    // Reset with three operations in flight.
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h4040_0000, 32'h4110_0000);
    send(32'h4000_0000, 32'h4080_0000);
    send(32'h3FC0_0000, 32'h4010_0000);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_y", y, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    cyc_q.delete();
    tim_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rstn       = 1'b1;
    out_ready  = 1'b1;
    timed_mode = 1'b1;
    send(32'h4080_0000, 32'h4180_0000);
    idle();
    drain();
    repeat (5) @(negedge clk);
    #1;
    check("final_out_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsquare.md
# fsquare

Pipelined single-precision squaring unit, y = x·x, the inverse companion of the table-driven square-root unit in the FPU. It accepts IEEE-754 binary32 operands over a valid/ready handshake and returns the rounded square three cycles later. It is used to check square-root results (sqrt(x)² ≈ x) and serves as a dedicated squaring datapath for the core.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operand x is presented
- in_ready  out  1  unit accepts x this cycle
- x  in  32  binary32 operand
- out_valid  out  1  y holds a result
- out_ready  in  1  consumer takes y this cycle
- y  out  32  binary32 result

## Operation
- Fields: s = x[31], e = x[30:23], f = x[22:0], m = {1, f} (24 bits). Sign is ignored and the result sign is always 0.
- Product: p = m·m, 48 bits, with p in [2^46, 2^48).
- Normalise:
  - If p[47] = 1: mant = p[46:24], rnd = p[23], n = 1.
  - Otherwise: mant = p[45:23], rnd = p[22], n = 0.
- Round half-up on magnitude: mant' = mant + rnd. If mant = all ones and rnd = 1, carry c = 1 and mant' = 0.
- Exponent: E = 2e − 127 + n + c, computed in a 10-bit signed word.
- Result selection, in priority order:
  - e = 0 (zero or denormal input; denormals are flushed): y = 0x00000000.
  - E ≥ 255: y = 0x7F800000 (+inf).
  - E ≤ 0: y = 0x00000000 (flush to zero, no denormal output).
  - Otherwise: y = {0, E[7:0], mant'}.
- e = 255 is handled as described under Configuration.

## Timing
- Three-stage pipeline:
  - S1 registers x and a valid bit.
  - S2 registers p and the decoded flags.
  - S3 normalises and rounds into the y/out_valid register.
- Latency: exactly 3 clk edges from the accepting edge (in_valid && in_ready) to out_valid = 1, provided out_ready = 1.
- Throughput: one operation per cycle.
- Advance enable: adv = !out_valid || out_ready. All stages shift only when adv = 1, and in_ready = adv (combinational).
- Bubbles travel with valid = 0. A stage whose valid bit is 0 still shifts, so gaps do not stall.
- While out_valid = 1 and out_ready = 0:
  - y and out_valid hold steady.
  - in_ready = 0 and no input is lost.
  - Results leave in the order the operands were accepted.
- x is sampled only on an accepting edge. The value of x when in_valid = 0 is don't-care.
- Reset (rstn low, any time, including mid-operation):
  - All valid bits clear immediately, so out_valid = 0 and in_ready = 1.
  - y = 0x00000000.
  - In-flight operations are discarded.
  - Data registers other than y need no reset.

## Configuration
- FSQUARE_SPECIAL_EN defined: e = 255 is decoded as a special value.
  - f = 0 gives y = 0x7F800000.
  - f ≠ 0 gives y = 0x7FC00000 (quiet NaN).
  - This check has priority over every other case.
- Macro undefined: e = 255 takes the normal arithmetic path, which always overflows to +inf. This matches the square-root unit, which has no special-value handling.

## Structure
- Shared package fpu_pkg holds:
  - BIAS = 127, EXP_MAX = 255, POS_INF = 32'h7F800000, QNAN = 32'h7FC00000.
  - A typedef for the unpacked float (sign, exp[7:0], frac[22:0]).
- One sub-module, fsquare_round: combinational S3 logic (normalise, round, exponent, result select). It takes p, e and the special flags and outputs the 32-bit result, so it can be unit-tested on its own.
- The top level owns the pipeline registers, valid bits and handshake.

## Test plan
- 0x40400000 (3.0) with out_ready = 1 → 0x41100000 (9.0), out_valid exactly 3 cycles after acceptance.
- 0xBFC00000 (−1.5) → 0x40100000 (2.25), sign cleared. 0x3FFFFFFF → 0x407FFFFE (rnd = 0 path).
- Overflow and underflow:
  - 0x7F000000 (2^127) → 0x7F800000.
  - 0x1F800000 (2^−64) → 0x00000000.
  - 0x00000001 (denormal) → 0x00000000.
- Back-pressure:
  - Stream 6 distinct operands back-to-back with out_ready held low: in_ready must drop after 3 acceptances.
  - Then raise out_ready: all results appear in order, none duplicated or lost, and y is stable while stalled.
- Reset with 3 operations in flight: out_valid = 0 and y = 0 immediately. After release, a new operand produces a correct result 3 cycles later with no stale outputs.
- With FSQUARE_SPECIAL_EN defined: 0x7F800000 → 0x7F800000 and 0x7F800001 → 0x7FC00000. Without the macro: 0x7F800001 → 0x7F800000.
